// File: rtl/b01_deser.sv
// Serial-to-byte deserializer for the b01 stage output with a small FWFT FIFO and event counters.
// Optional 9th even-parity bit per frame is enabled by defining B01_DESER_PARITY_EN.
module b01_deser #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             outp_in,
  input  logic             overflw_in,
  input  logic             en,
  input  logic             sync,
  input  logic             clr,
  output logic [7:0]       dout,
  output logic             dout_ovf,
  output logic             dout_perr,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef B01_DESER_PARITY_EN
  typedef enum logic [0:0] {SHIFT = 1'b0, PAR = 1'b1} state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [0:0] {SHIFT = 1'b0} state_t;
`endif

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sreg;
  logic        ovf_acc;

  state_t      cur_state;
  logic [2:0]  cur_cnt;
  logic        cur_acc;
  logic [7:0]  shifted;
  logic        frame_ovf;
  logic        complete;
  logic [7:0]  frame_data;
  logic        frame_perr;

  logic [9:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   count;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_next;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [9:0]    wdata;
  logic [9:0]    head_next;

  // Frame assembly view: sync makes this edge behave as the start of a fresh frame
  always_comb begin
    cur_state  = sync ? SHIFT : state;
    cur_cnt    = sync ? 3'd0 : bit_cnt;
    cur_acc    = sync ? 1'b0 : ovf_acc;
    shifted    = {outp_in, sreg[7:1]};
    frame_ovf  = cur_acc | overflw_in;
    complete   = 1'b0;
    frame_data = sreg;
    frame_perr = 1'b0;
    if (en) begin
      case (cur_state)
        SHIFT: begin
          if (cur_cnt == 3'd7) begin
`ifndef B01_DESER_PARITY_EN
            complete   = 1'b1;
            frame_data = shifted;
`else
            complete   = 1'b0;
`endif
          end else begin
            complete = 1'b0;
          end
        end
`ifdef B01_DESER_PARITY_EN
        PAR: begin
          complete   = 1'b1;
          frame_data = sreg;
          frame_perr = even_par(sreg) ^ outp_in;
        end
`endif
        default: complete = 1'b0;
      endcase
    end else begin
      complete = 1'b0;
    end
  end

  // Deserializer FSM: bit counter, shift register and overflow accumulator
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SHIFT;
      bit_cnt <= 3'd0;
      sreg    <= 8'd0;
      ovf_acc <= 1'b0;
    end else if (en) begin
      case (cur_state)
        SHIFT: begin
          sreg    <= shifted;
          ovf_acc <= frame_ovf;
          if (cur_cnt == 3'd7) begin
            bit_cnt <= 3'd0;
`ifdef B01_DESER_PARITY_EN
            state   <= PAR;
`else
            state   <= SHIFT;
            ovf_acc <= 1'b0;
`endif
          end else begin
            bit_cnt <= cur_cnt + 3'd1;
            state   <= SHIFT;
          end
        end
        default: begin
          state   <= SHIFT;
          bit_cnt <= 3'd0;
          ovf_acc <= 1'b0;
        end
      endcase
    end else begin
      state   <= cur_state;
      bit_cnt <= cur_cnt;
      ovf_acc <= cur_acc;
    end
  end

  // FIFO control; a full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    pop       = dout_valid & dout_ready;
    full      = (count == DEPTH_CNT);
    push      = complete & (~full | pop);
    drop      = complete & ~push;
    wdata     = {frame_ovf, frame_perr, frame_data};
    rd_next   = pop ? (rd_idx + {{(AW-1){1'b0}}, 1'b1}) : rd_idx;
    case ({push, pop})
      2'b10:   count_next = count + {{AW{1'b0}}, 1'b1};
      2'b01:   count_next = count - {{AW{1'b0}}, 1'b1};
      default: count_next = count;
    endcase
    if (push && (count == {{AW{1'b0}}, pop})) begin
      head_next = wdata;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_idx] <= wdata;
    end
  end

  // FIFO pointers and registered head-of-FIFO outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx     <= {AW{1'b0}};
      rd_idx     <= {AW{1'b0}};
      count      <= {(AW+1){1'b0}};
      dout_valid <= 1'b0;
      dout       <= 8'd0;
      dout_ovf   <= 1'b0;
      dout_perr  <= 1'b0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_idx     <= rd_next;
      count      <= count_next;
      dout_valid <= (count_next != {(AW+1){1'b0}});
      if (count_next != {(AW+1){1'b0}}) begin
        dout_ovf  <= head_next[9];
        dout_perr <= head_next[8];
        dout      <= head_next[7:0];
      end
    end
  end

  // Saturating event counters and sticky drop flag; clr wins over increments
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_cnt  <= {CNT_W{1'b0}};
      drop_cnt <= {CNT_W{1'b0}};
      dropped  <= 1'b0;
    end else if (clr) begin
      ovf_cnt  <= {CNT_W{1'b0}};
      drop_cnt <= {CNT_W{1'b0}};
      dropped  <= 1'b0;
    end else begin
      if (complete && frame_ovf && (ovf_cnt != CNT_MAX)) begin
        ovf_cnt <= ovf_cnt + CNT_ONE;
      end
      if (drop) begin
        dropped <= 1'b1;
        if (drop_cnt != CNT_MAX) begin
          drop_cnt <= drop_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_b01_deser.sv
// Directed bench for b01_deser; counters built 2 bits wide so saturation is reachable quickly.
module tb_b01_deser;

`ifdef B01_DESER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       outp_in = 1'b0;
  logic       overflw_in = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] dout;
  logic       dout_ovf;
  logic       dout_perr;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [1:0] ovf_cnt;
  logic [1:0] drop_cnt;
  logic       dropped;

  int n_cmp = 0;
  int n_err = 0;

  b01_deser #(.DEPTH(4), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .outp_in(outp_in), .overflw_in(overflw_in),
    .en(en), .sync(sync), .clr(clr), .dout(dout), .dout_ovf(dout_ovf),
    .dout_perr(dout_perr), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt), .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [8:0] bits, input int n, input logic [8:0] mask,
                           input logic rdy_last, input logic clr_last, input logic sync_first);
    for (int i = 0; i < n; i++) begin
      outp_in    = bits[i];
      overflw_in = mask[i];
      en         = 1'b1;
      sync       = sync_first && (i == 0);
      dout_ready = rdy_last && (i == n - 1);
      clr        = clr_last && (i == n - 1);
      tick();
    end
    en = 1'b0; sync = 1'b0; dout_ready = 1'b0; clr = 1'b0; overflw_in = 1'b0;
  endtask

  function automatic logic [8:0] fr(input logic [7:0] d);
    return {^d, d};
  endfunction

  task automatic frame(input logic [7:0] d, input logic [7:0] mask);
    send_bits(fr(d), NB, {1'b0, mask}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
    chk({tag, "_data"}, 32'(dout), 32'(d));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_flags", 32'({dout_ovf, dout_perr, dropped}), 32'd0);
    chk("rst_cnts", 32'({ovf_cnt, drop_cnt}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 0x85, no overflow, latency check before and after the completing bit
    send_bits(fr(8'h85), NB - 1, 9'd0, 1'b0, 1'b0, 1'b0);
    chk("lat_before", 32'(dout_valid), 32'd0);
    send_bits(fr(8'h85) >> (NB - 1), 1, 9'd0, 1'b0, 1'b0, 1'b0);
    chk("f85_valid", 32'(dout_valid), 32'd1);
    chk("f85_data", 32'(dout), 32'h85);
    chk("f85_ovf", 32'(dout_ovf), 32'd0);
    chk("f85_perr", 32'(dout_perr), 32'd0);
    pop_expect("f85_pop", 8'h85);
    chk("f85_empty", 32'(dout_valid), 32'd0);

    // overflow on bit 3 only
    frame(8'h85, 8'h08);
    chk("ovf_flag", 32'(dout_ovf), 32'd1);
    chk("ovf_cnt1", 32'(ovf_cnt), 32'd1);
    pop_expect("ovf_pop", 8'h85);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf", 32'(ovf_cnt), 32'd0);

    // five frames into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) frame(8'(i), 8'h00);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("dropped1", 32'(dropped), 32'd1);
    tick(); tick();
    chk("hold_data", 32'(dout), 32'h01);
    for (int i = 1; i <= 4; i++) pop_expect("drain5", 8'(i));
    chk("drain5_empty", 32'(dout_valid), 32'd0);

    // full FIFO with a pop on the completing edge of the fifth frame
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 1; i <= 4; i++) frame(8'(i), 8'h00);
    send_bits(fr(8'h05), NB, 9'd0, 1'b1, 1'b0, 1'b0);
    chk("simul_drop", 32'(drop_cnt), 32'd0);
    chk("simul_dropped", 32'(dropped), 32'd0);
    for (int i = 2; i <= 5; i++) pop_expect("simul", 8'(i));
    chk("simul_empty", 32'(dout_valid), 32'd0);

    // sync after 3 bits restarts the frame on the same edge that takes bit 0
    send_bits(9'b1_1111_1111, 3, 9'h1ff, 1'b0, 1'b0, 1'b0);
    send_bits(fr(8'hA5), NB, 9'd0, 1'b0, 1'b0, 1'b1);
    chk("sync_ovf", 32'(dout_ovf), 32'd0);
    pop_expect("sync", 8'hA5);
    chk("sync_single", 32'(dout_valid), 32'd0);

    // drop counter saturation at 3, ovf counted on a dropped frame, clr priority
    for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i), 8'h00);
    for (int i = 0; i < 4; i++) frame(8'hEE, 8'h00);
    chk("sat_drop", 32'(drop_cnt), 32'd3);
    send_bits(fr(8'hEE), NB, 9'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_prio_drop", 32'(drop_cnt), 32'd0);
    chk("clr_prio_flag", 32'(dropped), 32'd0);
    frame(8'hEE, 8'h01);
    chk("ovf_on_drop", 32'(ovf_cnt), 32'd1);
    chk("drop_after_clr", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) pop_expect("sat_drain", 8'h11 + 8'(i));

    // async reset mid-frame with data queued
    frame(8'h77, 8'h00);
    send_bits(9'b0_0000_1111, 4, 9'd0, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_cnts", 32'({ovf_cnt, drop_cnt, dropped}), 32'd0);
    tick();
    reset = 1'b0;
    frame(8'h3C, 8'h00);
    pop_expect("post_rst", 8'h3C);

`ifdef B01_DESER_PARITY_EN
    send_bits({1'b1, 8'h03}, 9, 9'd0, 1'b0, 1'b0, 1'b0);
    chk("perr_bad", 32'(dout_perr), 32'd1);
    pop_expect("perr_bad_pop", 8'h03);
    send_bits({1'b0, 8'h03}, 9, 9'd0, 1'b0, 1'b0, 1'b0);
    chk("perr_good", 32'(dout_perr), 32'd0);
    pop_expect("perr_good_pop", 8'h03);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/b01_deser.md
B01_DESER -- requirements
Module: b01_deser

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating event counters.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port outp_in  in  1  serial data bit from the upstream b01 stage (its outp).
REQ-006 SHALL have port overflw_in  in  1  overflow flag from the upstream b01 stage (its overflw).
REQ-007 SHALL have port en  in  1  sample qualifier; a bit is taken only on edges where en=1.
REQ-008 SHALL have port sync  in  1  frame restart; discards any partial frame.
REQ-009 SHALL have port clr  in  1  synchronous clear of both counters and the sticky drop flag.
REQ-010 SHALL have port dout  out  8  head-of-FIFO data byte.
REQ-011 SHALL have port dout_ovf  out  1  head-of-FIFO flag: overflw_in was 1 on any sampled bit of the frame.
REQ-012 SHALL have port dout_perr  out  1  head-of-FIFO parity error flag.
REQ-013 SHALL have port dout_valid  out  1  FIFO non-empty.
REQ-014 SHALL have port dout_ready  in  1  consumer accepts the head when dout_valid=1.
REQ-015 SHALL have port ovf_cnt  out  CNT_W  count of frames completed with ovf=1, saturating.
REQ-016 SHALL have port drop_cnt  out  CNT_W  count of frames lost to a full FIFO, saturating.
REQ-017 SHALL have port dropped  out  1  sticky flag, set on any drop.

Function
REQ-018 SHALL sample outp_in LSB-first into an 8-bit shift register on each edge with en=1, using a bit counter 0..7.
REQ-019 SHALL use states SHIFT and, with the macro, PAR; the transition is SHIFT->PAR after bit 7, PAR->SHIFT after the parity bit, or SHIFT->SHIFT after bit 7 without the macro.
REQ-020 SHALL OR overflw_in over all sampled bits of a frame (parity bit included) into the frame ovf flag.
REQ-021 SHALL complete a frame on the edge that samples its last bit, and write {data, ovf, perr} to the FIFO on that same edge; dout_valid SHALL be high in the following cycle (1-cycle latency).
REQ-022 SHALL present the FIFO head first-word-fall-through; a pop occurs on an edge with dout_valid=1 and dout_ready=1.
REQ-023 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-024 SHALL discard a completing frame otherwise, incrementing drop_cnt and setting dropped.
REQ-025 SHALL increment ovf_cnt for every completed frame with ovf=1, whether pushed or dropped.
REQ-026 SHALL hold both counters at 2^CNT_W-1 once reached.
REQ-027 SHALL, when sync=1, reset the bit counter, ovf accumulator and state to SHIFT; if en=1 on the same edge, that bit SHALL be taken as bit 0 of a new frame.
REQ-028 SHALL leave FIFO contents and the handshake unaffected by sync.
REQ-029 SHALL give clr priority over any increment on the same edge, so counters read 0 afterwards.
REQ-030 SHALL hold dout and flags stable while dout_valid=1 and dout_ready=0.

Reset
REQ-031 SHALL, on reset assertion and independent of clock, set state SHIFT, bit counter 0, shift register 0, FIFO empty, dout_valid 0, dout 0, dout_ovf 0, dout_perr 0, ovf_cnt 0, drop_cnt 0 and dropped 0.
REQ-032 SHALL, when reset asserts mid-frame, discard the partial frame; the first en=1 edge after release SHALL be bit 0.

Configuration
REQ-033 SHALL, when macro B01_DESER_PARITY_EN is defined, use 9-bit frames whose 9th bit is even parity over the 8 data bits, and set perr=1 on mismatch.
REQ-034 SHALL, when B01_DESER_PARITY_EN is undefined, use 8-bit frames with dout_perr tied 0 and no PAR state.

Verification
REQ-035 SHALL pass this case: en=1, bits 1,0,1,0,0,0,0,1 with overflw_in=0 -> dout=8'h85, dout_ovf=0, dout_valid high the cycle after bit 7.
REQ-036 SHALL pass this case: same frame with overflw_in=1 on bit 3 only -> dout_ovf=1, ovf_cnt=1.
REQ-037 SHALL pass this case: dout_ready=0, 5 frames of 8'h01..8'h05 (DEPTH=4) -> FIFO holds 01..04, drop_cnt=1, dropped=1.
REQ-038 SHALL pass this case: full FIFO, dout_ready=1 on the 5th frame's completing edge -> 8'h05 accepted, drop_cnt=0.
REQ-039 SHALL pass this case: sync after 3 bits, then 8'hA5 -> the single entry is 8'hA5.
REQ-040 SHALL pass this case (macro defined): 8'h03 with parity bit 1 -> dout_perr=1; with parity bit 0 -> dout_perr=0.
